// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: default widths and period,
// the clamp-stage upper limit, dead-time default and the run-state encoding.
// Optional dead-time insertion is selected with the PWM_DEADTIME_EN macro.
package pwm_pkg;

   localparam int CNT_W_DEF    = 16;
   localparam int PERIOD_DEF   = 32768;
   localparam int UMAX         = 32767;   // upper limit of the upstream clamp
   localparam int DEAD_CYC_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time insertion for the complementary drive pair. Every change of the
// base waveform blanks both outputs for DEAD_CYC cycles before the newly
// active side is driven, so a phase no longer than DEAD_CYC never produces a
// pulse and the two outputs are never high together. Used only when
// PWM_DEADTIME_EN is defined. DEAD_CYC must be at least 1.
module pwm_deadtime #(
   parameter int DEAD_CYC = 8
) (
   input  logic clk,
   input  logic reset_b,
   input  logic en,
   input  logic base,
   output logic hi,
   output logic lo
);

   localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

   logic          prev_q, prev_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          hi_q, hi_d;
   logic          lo_q, lo_d;

   // Restart the blanking count on each base edge, pass the settled level through afterwards
   always_comb begin
      prev_d = base;
      dcnt_d = dcnt_q;
      hi_d   = 1'b0;
      lo_d   = 1'b0;
      if (!en) begin
         prev_d = 1'b0;
         dcnt_d = '0;
      end else if (base != prev_q) begin
         dcnt_d = DW'(DEAD_CYC - 1);
      end else if (dcnt_q != '0) begin
         dcnt_d = dcnt_q - DW'(1);
      end else begin
         hi_d = prev_q;
         lo_d = !prev_q;
      end
   end

   // Blanking state and registered drive pair
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         prev_q <= 1'b0;
         dcnt_q <= '0;
         hi_q   <= 1'b0;
         lo_q   <= 1'b0;
      end else begin
         prev_q <= prev_d;
         dcnt_q <= dcnt_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/pwm_generator.sv
// Fixed-frequency PWM generator fed by the PI clamp stage. Duty words are
// captured at any time into a pending register and moved into the shadow
// register only at a period boundary, so every period is whole. Outputs are
// registered. Define PWM_DEADTIME_EN to insert dead time between the
// complementary outputs.
//
// Input handshake: data_valid is a single-cycle strobe with no back-pressure;
// data_in is taken on every clock edge where data_valid is 1.
module pwm_generator
   import pwm_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int PERIOD   = PERIOD_DEF,
   parameter int DEAD_CYC = DEAD_CYC_DEF
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             enable,
   input  logic [CNT_W-1:0] data_in,
   input  logic             data_valid,
   output logic             pwm_out,
   output logic             pwm_out_n,
   output logic             period_start,
   output logic [CNT_W-1:0] duty_active,
   output logic             dbg_state
);

   localparam logic [CNT_W:0]   PERIOD_W = (CNT_W + 1)'(PERIOD);
   localparam logic [CNT_W-1:0] TERM     = CNT_W'(PERIOD - 1);

   if (PERIOD < 2 || PERIOD > 2 ** CNT_W || DEAD_CYC < 1 || 2 ** CNT_W <= UMAX) begin : g_bad_param
      $error("pwm_generator: illegal CNT_W/PERIOD/DEAD_CYC combination");
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] duty_pend_q, duty_pend_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
   logic             period_start_q, period_start_d;
   logic             run_now, terminal, load, base;
   logic [CNT_W:0]   applied;

   // Run/idle sequencing; a dropped enable stops the counter immediately
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable)  state_d = RUN;
         RUN:     if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      run_now  = (state_q == RUN) && enable;
      terminal = (cnt_q == TERM);
      load     = ((state_q == IDLE) && enable) || (run_now && terminal);
      cnt_d    = '0;
      if (run_now) cnt_d = terminal ? '0 : cnt_q + CNT_W'(1);
   end

   // Duty double buffer: strobes land in pending; boundaries move them to shadow
   always_comb begin
      duty_pend_d = duty_pend_q;
      pend_d      = pend_q;
      duty_sh_d   = duty_sh_q;
      if (load) begin
         if (data_valid) begin
            duty_sh_d = data_in;          // coincident strobe bypasses pending
            pend_d    = 1'b0;
         end else if (pend_q) begin
            duty_sh_d = duty_pend_q;
            pend_d    = 1'b0;
         end
      end else if (data_valid) begin
         duty_pend_d = data_in;           // last strobe in a period wins
         pend_d      = 1'b1;
      end
   end

   // Saturating compare of the counter against the applied duty
   always_comb begin
      applied        = ({1'b0, duty_sh_q} >= PERIOD_W) ? PERIOD_W : {1'b0, duty_sh_q};
      base           = run_now && ({1'b0, cnt_q} < applied);
      period_start_d = run_now && (cnt_q == '0);
   end

   // Sequencer, counter, duty buffers and period strobe
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         duty_pend_q    <= '0;
         pend_q         <= 1'b0;
         duty_sh_q      <= '0;
         period_start_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         duty_pend_q    <= duty_pend_d;
         pend_q         <= pend_d;
         duty_sh_q      <= duty_sh_d;
         period_start_q <= period_start_d;
      end
   end

`ifdef PWM_DEADTIME_EN
   logic dt_hi, dt_lo;

   pwm_deadtime #(
      .DEAD_CYC (DEAD_CYC)
   ) u_deadtime (
      .clk     (clk),
      .reset_b (reset_b),
      .en      (run_now),
      .base    (base),
      .hi      (dt_hi),
      .lo      (dt_lo)
   );

   assign pwm_out   = dt_hi;
   assign pwm_out_n = dt_lo;
`else
   logic pwm_q, pwm_d, pwm_n_q, pwm_n_d;

   // Plain complementary drive, both low while idle
   always_comb begin
      pwm_d   = base;
      pwm_n_d = run_now && !base;
   end

   // Registered drive pair
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         pwm_q   <= 1'b0;
         pwm_n_q <= 1'b0;
      end else begin
         pwm_q   <= pwm_d;
         pwm_n_q <= pwm_n_d;
      end
   end

   assign pwm_out   = pwm_q;
   assign pwm_out_n = pwm_n_q;
`endif

   assign period_start = period_start_q;
   assign duty_active  = duty_sh_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator with PERIOD=16, DEAD_CYC=2. A
// cycle-level reference model built from the duty-buffering rules predicts
// {pwm_out, pwm_out_n, period_start, duty_active}; scenario tasks also check
// fixed duty ratios. With PWM_DEADTIME_EN the pwm bits are excluded from the
// model comparison and checked by the dead-time scenario instead.
module tb_pwm_generator;

   localparam int CNT_W    = 16;
   localparam int PERIOD   = 16;
   localparam int DEAD_CYC = 2;
   localparam int W        = CNT_W + 3;
`ifdef PWM_DEADTIME_EN
   localparam logic [W-1:0] MASK = {3'b001, {CNT_W{1'b1}}};
`else
   localparam logic [W-1:0] MASK = {W{1'b1}};
`endif

   logic             clk;
   logic             reset_b;
   logic             enable;
   logic [CNT_W-1:0] data_in;
   logic             data_valid;
   logic             pwm_out;
   logic             pwm_out_n;
   logic             period_start;
   logic [CNT_W-1:0] duty_active;
   logic             dbg_state;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];

   // reference model state
   bit               m_run;
   int               m_cnt;
   bit               m_pend;
   logic [CNT_W-1:0] m_pval;
   logic [CNT_W-1:0] m_sh;

   int n_checks;
   int n_pass;

   pwm_generator #(
      .CNT_W    (CNT_W),
      .PERIOD   (PERIOD),
      .DEAD_CYC (DEAD_CYC)
   ) dut (
      .clk          (clk),
      .reset_b      (reset_b),
      .enable       (enable),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .pwm_out      (pwm_out),
      .pwm_out_n    (pwm_out_n),
      .period_start (period_start),
      .duty_active  (duty_active),
      .dbg_state    (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_run  = 0;
      m_cnt  = 0;
      m_pend = 0;
      m_pval = '0;
      m_sh   = '0;
      exp_q.delete();
      obs_q.delete();
   endtask

   // drive one cycle, advance the model, record expected and observed outputs
   task automatic tick(input logic en, input logic dv, input logic [CNT_W-1:0] din);
      int   applied;
      logic act, hi, ps;
      enable     = en;
      data_valid = dv;
      data_in    = din;
      @(posedge clk);
      act     = m_run && en;
      applied = (int'(m_sh) > PERIOD) ? PERIOD : int'(m_sh);
      hi      = act && (m_cnt < applied);
      ps      = act && (m_cnt == 0);
      if (en && (!m_run || m_cnt == PERIOD - 1)) begin
         if (dv) begin
            m_sh   = din;
            m_pend = 0;
         end else if (m_pend) begin
            m_sh   = m_pval;
            m_pend = 0;
         end
      end else if (dv) begin
         m_pend = 1;
         m_pval = din;
      end
      m_cnt = act ? (m_cnt + 1) % PERIOD : 0;
      m_run = en;
      exp_q.push_back({hi, act && !hi, ps, m_sh});
      #1;
      obs_q.push_back({pwm_out, pwm_out_n, period_start, duty_active});
   endtask

   task automatic test_reset();
      logic [W-1:0] e, o;
      n_checks++;
      if ({pwm_out, pwm_out_n, period_start, duty_active, dbg_state} !== '0)
         $display("FAIL reset_state: outs=%h state=%b, want all 0",
                  {pwm_out, pwm_out_n, period_start, duty_active}, dbg_state);
      else n_pass++;
      model_reset();
      #2 reset_b = 1'b1;
      repeat (4) tick(0, 0, '0);
      for (int k = 0; exp_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if ((o & MASK) !== (e & MASK))
            $display("FAIL reset_idle[%0d]: got %h want %h", k, o, e);
         else n_pass++;
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] e, o;
      int hi_cnt, ps_cnt;
      tick(1, 1, 16'd4);
      repeat (16) tick(1, 0, '0);
      hi_cnt = 0;
      ps_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1, 0, '0);
         hi_cnt += int'(pwm_out);
         ps_cnt += int'(period_start);
      end
`ifndef PWM_DEADTIME_EN
      n_checks++;
      if (hi_cnt !== 4) $display("FAIL basic_high_count: got %0d want 4", hi_cnt);
      else n_pass++;
`endif
      n_checks++;
      if (ps_cnt !== 1) $display("FAIL basic_period_start: got %0d want 1", ps_cnt);
      else n_pass++;
      n_checks++;
      if (duty_active !== 16'd4) $display("FAIL basic_duty_active: got %0d want 4", duty_active);
      else n_pass++;
      for (int k = 0; exp_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if ((o & MASK) !== (e & MASK))
            $display("FAIL basic_seq[%0d]: got %h want %h", k, o, e);
         else n_pass++;
      end
   endtask

   task automatic test_double_buffer();
      logic [W-1:0] e, o;
      int hi_cnt;
      for (int g = 0; g < 40 && m_cnt != 5; g++) tick(1, 0, '0);
      tick(1, 1, 16'd12);
      n_checks++;
      if (duty_active !== 16'd4) $display("FAIL dbuf_hold: got %0d want 4", duty_active);
      else n_pass++;
      for (int g = 0; g < 40 && m_cnt != 0; g++) tick(1, 0, '0);
      n_checks++;
      if (duty_active !== 16'd12) $display("FAIL dbuf_apply: got %0d want 12", duty_active);
      else n_pass++;
      hi_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1, 0, '0);
         hi_cnt += int'(pwm_out);
      end
`ifndef PWM_DEADTIME_EN
      n_checks++;
      if (hi_cnt !== 12) $display("FAIL dbuf_high_count: got %0d want 12", hi_cnt);
      else n_pass++;
`endif
      for (int g = 0; g < 40 && m_cnt != 2; g++) tick(1, 0, '0);
      tick(1, 1, 16'd7);
      for (int g = 0; g < 40 && m_cnt != 6; g++) tick(1, 0, '0);
      tick(1, 1, 16'd9);
      for (int g = 0; g < 40 && m_cnt != 0; g++) tick(1, 0, '0);
      n_checks++;
      if (duty_active !== 16'd9) $display("FAIL dbuf_last_wins: got %0d want 9", duty_active);
      else n_pass++;
      repeat (4) tick(1, 0, '0);
      for (int k = 0; exp_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if ((o & MASK) !== (e & MASK))
            $display("FAIL dbuf_seq[%0d]: got %h want %h", k, o, e);
         else n_pass++;
      end
   endtask

   task automatic test_boundary();
      logic [W-1:0] e, o;
      int hi_cnt, lo_cnt;
      for (int g = 0; g < 40 && m_cnt != 15; g++) tick(1, 0, '0);
      tick(1, 1, 16'd10);
      n_checks++;
      if (duty_active !== 16'd10) $display("FAIL bnd_bypass: got %0d want 10", duty_active);
      else n_pass++;
      hi_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1, 0, '0);
         hi_cnt += int'(pwm_out);
      end
`ifndef PWM_DEADTIME_EN
      n_checks++;
      if (hi_cnt !== 10) $display("FAIL bnd_high_count10: got %0d want 10", hi_cnt);
      else n_pass++;
`endif
      // duty 0: never high
      tick(1, 1, 16'd0);
      for (int g = 0; g < 40 && m_cnt != 0; g++) tick(1, 0, '0);
      hi_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         tick(1, 0, '0);
         hi_cnt += int'(pwm_out);
      end
      n_checks++;
      if (hi_cnt !== 0) $display("FAIL bnd_zero_duty: pwm high %0d cycles want 0", hi_cnt);
      else n_pass++;
      // clamp maximum: saturates to constant high
      tick(1, 1, 16'd32767);
      for (int g = 0; g < 40 && m_cnt != 0; g++) tick(1, 0, '0);
      hi_cnt = 0;
      lo_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         tick(1, 0, '0);
         hi_cnt += int'(pwm_out);
         lo_cnt += int'(pwm_out_n);
      end
      n_checks++;
      if (hi_cnt !== 32 || lo_cnt !== 0)
         $display("FAIL bnd_full_duty: pwm high %0d pwm_n high %0d want 32 and 0", hi_cnt, lo_cnt);
      else n_pass++;
      for (int k = 0; exp_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if ((o & MASK) !== (e & MASK))
            $display("FAIL bnd_seq[%0d]: got %h want %h", k, o, e);
         else n_pass++;
      end
   endtask

   task automatic test_enable_drop();
      logic [W-1:0] e, o;
      tick(1, 1, 16'd6);
      for (int g = 0; g < 40 && m_cnt != 7; g++) tick(1, 0, '0);
      tick(0, 0, '0);
      n_checks++;
      if (pwm_out !== 1'b0 || pwm_out_n !== 1'b0 || dbg_state !== 1'b0)
         $display("FAIL en_drop: pwm=%b pwm_n=%b state=%b want 0 0 0", pwm_out, pwm_out_n, dbg_state);
      else n_pass++;
      repeat (3) tick(0, 0, '0);
      tick(1, 0, '0);
      tick(1, 0, '0);
      n_checks++;
      if (period_start !== 1'b1) $display("FAIL en_restart_ps: got %b want 1", period_start);
      else n_pass++;
      repeat (18) tick(1, 0, '0);
      for (int k = 0; exp_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if ((o & MASK) !== (e & MASK))
            $display("FAIL en_seq[%0d]: got %h want %h", k, o, e);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [W-1:0]     e, o;
      logic             en, dv;
      logic [CNT_W-1:0] din;
      int               ovl;
      ovl = 0;
      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 99) < 95);
         dv = ($urandom_range(0, 99) < 12);
         case ($urandom_range(0, 3))
            0:       din = CNT_W'($urandom_range(0, 20));
            1:       din = '0;
            2:       din = 16'd32767;
            default: din = CNT_W'($urandom_range(0, 65535));
         endcase
         tick(en, dv, din);
         if (pwm_out && pwm_out_n) ovl++;
      end
      n_checks++;
      if (ovl !== 0) $display("FAIL rand_overlap: %0d cycles with both high, want 0", ovl);
      else n_pass++;
      for (int k = 0; exp_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if ((o & MASK) !== (e & MASK))
            $display("FAIL rand_seq[%0d]: got %h want %h", k, o, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] e, o;
      tick(1, 1, 16'd8);
      repeat (21) tick(1, 0, '0);
      exp_q.delete();
      obs_q.delete();
      #2 reset_b = 1'b0;
      #1;
      n_checks++;
      if ({pwm_out, pwm_out_n, period_start, duty_active, dbg_state} !== '0)
         $display("FAIL reset_mid: outs=%h state=%b want all 0",
                  {pwm_out, pwm_out_n, period_start, duty_active}, dbg_state);
      else n_pass++;
      enable = 1'b0;
      model_reset();
      @(posedge clk);
      #3 reset_b = 1'b1;
      repeat (5) tick(0, 0, '0);
      for (int k = 0; exp_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if ((o & MASK) !== (e & MASK))
            $display("FAIL reset_mid_idle[%0d]: got %h want %h", k, o, e);
         else n_pass++;
      end
   endtask

`ifdef PWM_DEADTIME_EN
   task automatic test_deadtime();
      int hi_cnt, lo_cnt, gap_cnt, ovl;
      tick(1, 1, 16'd8);
      repeat (40) tick(1, 0, '0);
      hi_cnt = 0; lo_cnt = 0; gap_cnt = 0; ovl = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1, 0, '0);
         hi_cnt  += int'(pwm_out);
         lo_cnt  += int'(pwm_out_n);
         gap_cnt += int'(!pwm_out && !pwm_out_n);
         ovl     += int'(pwm_out && pwm_out_n);
      end
      n_checks++;
      if (hi_cnt !== 6 || lo_cnt !== 6 || gap_cnt !== 4 || ovl !== 0)
         $display("FAIL dt_duty8: hi=%0d lo=%0d gap=%0d ovl=%0d want 6 6 4 0", hi_cnt, lo_cnt, gap_cnt, ovl);
      else n_pass++;
      tick(1, 1, 16'd2);
      repeat (40) tick(1, 0, '0);
      hi_cnt = 0; lo_cnt = 0; ovl = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1, 0, '0);
         hi_cnt += int'(pwm_out);
         lo_cnt += int'(pwm_out_n);
         ovl    += int'(pwm_out && pwm_out_n);
      end
      n_checks++;
      if (hi_cnt !== 0 || lo_cnt !== 12 || ovl !== 0)
         $display("FAIL dt_duty2: hi=%0d lo=%0d ovl=%0d want 0 12 0", hi_cnt, lo_cnt, ovl);
      else n_pass++;
      exp_q.delete();
      obs_q.delete();
   endtask
`endif

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      reset_b    = 1'b0;
      enable     = 1'b0;
      data_valid = 1'b0;
      data_in    = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_double_buffer();
      test_boundary();
      test_enable_drop();
      test_random();
      test_reset_mid();
`ifdef PWM_DEADTIME_EN
      test_deadtime();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
